reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the 16x32 register file: N asynchronous read ports, one synchronous write port, asynchronous reset of all storage.
- Adds write-to-read bypass and a per-register pending-write scoreboard (busy bits plus a live count) so the pipelined datapath can detect RAW hazards.
- Sits in the decode stage: decode reads operands and issues destinations; writeback drives the write port.

Parameters:
- data_width, 32, width of each register.
- addr_width, 4, address width; depth = 2**addr_width.
- num_read, 2, number of read ports (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all registers, busy bits and count.
- we  in  1  write enable (writeback).
- wr_addr  in  addr_width  write address.
- wr_data  in  data_width  write data.
- rd_addr  in  num_read*addr_width  flattened read addresses; port i occupies [i*addr_width +: addr_width].
- rd_data  out  num_read*data_width  flattened read data, same packing.
- rd_busy  out  num_read  per-port pending-write flag for the addressed register.
- issue  in  1  mark register issue_addr as pending (instruction issued with this destination).
- issue_addr  in  addr_width  destination being issued.
- flush  in  1  clear all busy bits (pipeline squash).
- busy_count  out  addr_width+1  number of registers currently pending.

Behaviour:
- Reset (async, any time, including mid-operation):
  - All registers become 0; all busy bits 0; busy_count 0.
  - rd_data reflects the zeroed array combinationally; rd_busy is 0.
- Write:
  - On posedge clk with we=1: reg[wr_addr] <= wr_data.
  - Writes are permitted whether or not the target is busy.
- Read (combinational, zero latency):
  - If we=1 and rd_addr_i==wr_addr, rd_data_i = wr_data (write-first bypass).
  - Otherwise rd_data_i = reg[rd_addr_i].
  - Any number of ports may read the same address.
- Busy bits, next-state per register r, in priority order:
  1. flush=1: busy[r] <= 0, then rule 3 still applies.
  2. we=1 and wr_addr==r: the write clears busy[r].
  3. issue=1 and issue_addr==r: busy[r] <= 1. Issue wins over the same-cycle write-clear and over flush, because the issuing instruction is younger.
- rd_busy_i:
  - Equals busy[rd_addr_i] & ~(we & wr_addr==rd_addr_i); the same-cycle write is bypassed, so the register is not reported as a hazard.
  - A same-cycle issue does not affect rd_busy until the next cycle.
- busy_count:
  - Registered; equals the population count of the busy vector after each edge.
  - Implemented as an up/down counter, not a popcount:
    - +1 when issue targets a non-busy register and no same-cycle write-clear hits it.
    - -1 when a write clears a busy register not being re-issued.
    - Net 0 when issue and write hit the same busy register.
  - On flush: next count = 1 if issue=1, else 0.
  - Maximum value is 2**addr_width, hence addr_width+1 bits; no wrap can occur.
- Re-issuing an already-busy register leaves the bit at 1 and the count unchanged.
- A write to a non-busy register changes neither the busy bits nor the count.
- No reset-value dependence on inputs; every output is defined while reset is asserted.

Decomposition:
- Package reg_file_pkg holds:
  - default width constants: DATA_W=32, ADDR_W=4, NREAD=2;
  - function popcount, used by the bench's scoreboard model and by RTL assertions only.
- One sub-module, reg_scoreboard: busy vector, flush/issue/write priority and the busy_count counter.
- The top module holds the storage array, read muxes and bypass, and instantiates reg_scoreboard.

Test Plan:
- Reset then read: assert reset; read addr 3 and 15 -> rd_data=0, rd_busy=0, busy_count=0. Write 0xDEADBEEF to r3 and read next cycle -> 0xDEADBEEF.
- Bypass: we=1, wr_addr=5, wr_data=0x12345678, rd_addr0=5, rd_addr1=5 in the same cycle -> both ports show 0x12345678 before the edge.
- Scoreboard: issue r7 -> next cycle rd_busy=1 for r7 and busy_count=1. Write r7=0xA5 -> rd_busy=0 in that cycle (bypass), busy 0 after the edge, count 0.
- Simultaneous events: r4 busy; same cycle we r4 and issue r4 -> r4 still busy, count unchanged. Issue r9 plus flush with r2 and r6 busy -> only r9 busy, count=1.
- Fill: issue all 16 registers on consecutive cycles -> busy_count=16 (0b10000). Re-issue r0 -> count stays 16.
- Async reset mid-operation: with r1 busy and r1=0x55, raise reset between clock edges -> rd_data=0, rd_busy=0 and busy_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared width defaults and a popcount helper for the scoreboarded register file
package reg_file_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NREAD = 2;
  function automatic int popcount(input logic [255:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 256; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/writeback bus of the scoreboarded register file
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int data_width = DATA_W,
  parameter int addr_width = ADDR_W,
  parameter int num_read = NREAD
) ();
  logic we;
  logic [addr_width-1:0] wr_addr;
  logic [data_width-1:0] wr_data;
  logic [num_read*addr_width-1:0] rd_addr;
  logic [num_read*data_width-1:0] rd_data;
  logic [num_read-1:0] rd_busy;
  logic issue;
  logic [addr_width-1:0] issue_addr;
  logic flush;
  logic [addr_width:0] busy_count;
  modport master(
    output we, wr_addr, wr_data, rd_addr, issue, issue_addr, flush,
    input rd_data, rd_busy, busy_count
  );
  modport slave(
    input we, wr_addr, wr_data, rd_addr, issue, issue_addr, flush,
    output rd_data, rd_busy, busy_count
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard: per-register pending-write bits with a live up/down count
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int addr_width = ADDR_W,
  localparam int depth = 2 ** addr_width,
  localparam int cw = addr_width + 1
) (
  input logic clk,
  input logic reset,
  input logic we,
  input logic [addr_width-1:0] wr_addr,
  input logic issue,
  input logic [addr_width-1:0] issue_addr,
  input logic flush,
  output logic [depth-1:0] busy,
  output logic [addr_width:0] busy_count
);
  logic [depth-1:0] iss_mask, wr_mask, busy_next;
  logic inc, dec;
  // issue is the youngest event, so it overrides both flush and the write-clear
  always_comb begin
    iss_mask = depth'(issue) << issue_addr;
    wr_mask = depth'(we) << wr_addr;
    busy_next = iss_mask | (flush ? '0 : busy & ~wr_mask);
    inc = issue & ~busy[issue_addr];
    dec = we & busy[wr_addr] & ~(issue & (issue_addr == wr_addr));
  end
  // count tracks the busy vector incrementally instead of re-counting it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busy <= '0;
      busy_count <= '0;
    end else begin
      busy <= busy_next;
      busy_count <= flush ? cw'(issue) : busy_count + cw'(inc) - cw'(dec);
    end
  count_matches_busy: assert property (@(posedge clk) disable iff (reset)
    int'(busy_count) == popcount(256'(busy)));
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with write-first bypass and RAW-hazard scoreboard
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int data_width = DATA_W,
  parameter int addr_width = ADDR_W,
  parameter int num_read = NREAD
) (
  input logic clk,
  input logic reset,
  reg_file_sb_if.slave bus
);
  localparam int depth = 2 ** addr_width;
  logic [data_width-1:0] regs [depth];
  logic [depth-1:0] busy;
  // storage: writes land regardless of the target's busy state
  always_ff @(posedge clk or posedge reset)
    if (reset) regs <= '{default: '0};
    else if (bus.we) regs[bus.wr_addr] <= bus.wr_data;
  reg_scoreboard #(.addr_width(addr_width)) sb (
    .clk(clk),
    .reset(reset),
    .we(bus.we),
    .wr_addr(bus.wr_addr),
    .issue(bus.issue),
    .issue_addr(bus.issue_addr),
    .flush(bus.flush),
    .busy(busy),
    .busy_count(bus.busy_count)
  );
  for (genvar i = 0; i < num_read; i++) begin : g_rd
    logic [addr_width-1:0] ra;
    logic hit;
    assign ra = bus.rd_addr[i*addr_width +: addr_width];
    assign hit = bus.we & ~reset & (bus.wr_addr == ra);
    assign bus.rd_data[i*data_width +: data_width] = hit ? bus.wr_data : regs[ra];
    assign bus.rd_busy[i] = busy[ra] & ~hit;
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench with a rule-level reference model
module tb_reg_file_sb;
  import reg_file_pkg::*;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  reg_file_sb_if bus ();
  reg_file_sb dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [63:0] data;
    logic [1:0] busy;
    logic [4:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] mem [16];
  logic [15:0] bsy;
  int n_cmp = 0;
  int n_bad = 0;
  function automatic void model_clear();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    bsy = '0;
  endfunction
  function automatic void model_edge();
    if (reset) model_clear();
    else begin
      if (bus.we) mem[bus.wr_addr] = bus.wr_data;
      if (bus.flush) bsy = '0;
      if (bus.we) bsy[bus.wr_addr] = 1'b0;
      if (bus.issue) bsy[bus.issue_addr] = 1'b1;
    end
  endfunction
  function automatic exp_t expect_now();
    exp_t x;
    logic [3:0] ra;
    logic hit;
    for (int p = 0; p < 2; p++) begin
      ra = bus.rd_addr[p*4 +: 4];
      hit = bus.we && !reset && bus.wr_addr == ra;
      x.data[p*32 +: 32] = hit ? bus.wr_data : mem[ra];
      x.busy[p] = bsy[ra] && !hit;
    end
    x.cnt = 5'(popcount(256'(bsy)));
    return x;
  endfunction
  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction
  task automatic drive(input logic r, input logic w, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] a0, input logic [3:0] a1, input logic iss,
                       input logic [3:0] ia, input logic fl);
    @(posedge clk);
    model_edge();
    #1;
    reset = r;
    bus.we = w;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_addr = {a1, a0};
    bus.issue = iss;
    bus.issue_addr = ia;
    bus.flush = fl;
    if (r) model_clear();
    q.push_back(expect_now());
  endtask
  task automatic async_reset_mid();
    @(posedge clk);
    model_edge();
    #1;
    bus.we = 0;
    bus.issue = 0;
    bus.flush = 0;
    bus.rd_addr = {4'd1, 4'd1};
    #2;
    reset = 1;
    model_clear();
    q.push_back(expect_now());
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      e = q.pop_front();
      check("rd_data0", bus.rd_data[31:0], e.data[31:0]);
      check("rd_data1", bus.rd_data[63:32], e.data[63:32]);
      check("rd_busy0", 32'(bus.rd_busy[0]), 32'(e.busy[0]));
      check("rd_busy1", 32'(bus.rd_busy[1]), 32'(e.busy[1]));
      check("busy_count", 32'(bus.busy_count), 32'(e.cnt));
    end
  initial begin
    model_clear();
    drive(1, 0, 0, 0, 3, 15, 0, 0, 0);
    drive(0, 1, 3, 32'hDEADBEEF, 3, 15, 0, 0, 0);
    drive(0, 0, 0, 0, 3, 3, 0, 0, 0);
    drive(0, 1, 5, 32'h12345678, 5, 5, 0, 0, 0);
    drive(0, 0, 0, 0, 7, 5, 1, 7, 0);
    drive(0, 1, 7, 32'hA5, 7, 7, 0, 0, 0);
    drive(0, 0, 0, 0, 7, 7, 0, 0, 0);
    drive(0, 0, 0, 0, 4, 4, 1, 4, 0);
    drive(0, 1, 4, 32'h44, 4, 0, 1, 4, 0);
    drive(0, 0, 0, 0, 4, 4, 0, 0, 0);
    drive(0, 0, 0, 0, 2, 6, 1, 2, 0);
    drive(0, 0, 0, 0, 2, 6, 1, 6, 0);
    drive(0, 0, 0, 0, 2, 6, 1, 9, 1);
    drive(0, 0, 0, 0, 9, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 6, 9, 0, 0, 1);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 4'(i), 0, 1, 4'(i), 0);
    drive(0, 0, 0, 0, 15, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 15, 0, 0, 0);
    drive(0, 1, 1, 32'h55, 1, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 1, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0);
    async_reset_mid();
    drive(1, 0, 0, 0, 1, 3, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(31) == 0, 1'($urandom), 4'($urandom), $urandom, 4'($urandom),
            4'($urandom), 1'($urandom), 4'($urandom), $urandom_range(15) == 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
